// File: rtl/fb_rd_unpacker.sv
// Frame-buffer read unpacker: pulls words from an FWFT line FIFO and emits n pixel
// units per active-video beat, with a 2-stage output pipeline aligned to the sync inputs.
module fb_rd_unpacker #(
  parameter int C_WORD_UNITS = 32,
  parameter int C_UNIT_BITS  = 8,
  parameter bit C_LINE_ALIGN = 1'b1
) (
  input  logic                                  clk_in,
  input  logic                                  rst,
  input  logic                                  vs_i,
  input  logic                                  hs_i,
  input  logic                                  de_i,
  input  logic [$clog2(C_WORD_UNITS+1)-1:0]     units_i,
  input  logic [C_WORD_UNITS*C_UNIT_BITS-1:0]   fifo_data_i,
  input  logic                                  fifo_empty_i,
  output logic                                  fifo_rd_o,
  output logic                                  vs_o,
  output logic                                  hs_o,
  output logic                                  de_o,
  output logic [C_WORD_UNITS*C_UNIT_BITS-1:0]   data_o,
  output logic                                  underflow_o,
  output logic                                  cfg_err_o
);

  localparam int W  = C_WORD_UNITS;
  localparam int B  = C_UNIT_BITS;
  localparam int WB = W * B;
  localparam int RB = (W - 1) * B;
  localparam int CW = 2 * WB;
  localparam int NW = $clog2(W + 1);
  localparam int LW = $clog2(W) + 1;

  logic [NW-1:0] n_lat;
  logic [RB-1:0] resid;
  logic [LW-1:0] lvl;
  logic          vs_d, de_d;
  logic          s1_vs, s1_hs, s1_de;
  logic [WB-1:0] s1_data;

  logic          cfg_legal;
  logic [LW-1:0] n_ext;
  logic          need_word;
  logic          pop, starve;
  logic [CW-1:0] combined;
  logic [WB-1:0] all_ones, unit_mask, beat_data;
  logic [RB-1:0] next_resid;
  logic [LW-1:0] next_lvl;
  logic          vs_rise, de_fall;

  assign cfg_legal = (units_i != '0) && (units_i <= NW'(W));
  assign n_ext     = LW'(n_lat);
  assign need_word = (lvl < n_ext);
  assign all_ones  = '1;
  assign unit_mask = ~(all_ones << (n_lat * B));
  assign vs_rise   = vs_i & ~vs_d;
  assign de_fall   = de_d & ~de_i;
  assign fifo_rd_o = pop;

  // Beat datapath: residual units sit LSB-aligned, a popped word is appended above them.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    pop        = 1'b0;
    starve     = 1'b0;
    combined   = '0;
    beat_data  = '0;
    next_resid = resid;
    next_lvl   = lvl;
    if (de_i && !rst) begin
      if (!need_word) begin
        combined = CW'(resid);
      end else if (!fifo_empty_i) begin
        pop      = 1'b1;
        combined = CW'(resid) | (CW'(fifo_data_i) << (lvl * B));
      end else begin
        starve = 1'b1;
      end
      if (!starve) begin
        beat_data  = combined[WB-1:0] & unit_mask;
        next_resid = RB'(combined >> (n_lat * B));
        next_lvl   = need_word ? (lvl + LW'(W) - n_ext) : (lvl - n_ext);
      end
    end
  end

  // Unit count is sampled during reset and vertical sync only; illegal counts fall back to W.
  always_ff @(posedge clk_in) begin
    if (rst || vs_i) begin
      if (cfg_legal) begin
        n_lat     <= units_i;
        cfg_err_o <= 1'b0;
      end else begin
        n_lat     <= NW'(W);
        cfg_err_o <= ~rst;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    // NOTE: state registers use non-blocking assignments so every read sees the pre-edge value.
    if (rst) begin
      vs_d        <= 1'b0;
      de_d        <= 1'b0;
      lvl         <= '0;
      resid       <= '0;
      underflow_o <= 1'b0;
      s1_vs       <= 1'b0;
      s1_hs       <= 1'b0;
      s1_de       <= 1'b0;
      s1_data     <= '0;
      vs_o        <= 1'b0;
      hs_o        <= 1'b0;
      de_o        <= 1'b0;
      data_o      <= '0;
    end else begin
      vs_d    <= vs_i;
      de_d    <= de_i;
      s1_vs   <= vs_i;
      s1_hs   <= hs_i;
      s1_de   <= de_i;
      s1_data <= beat_data;
      vs_o    <= s1_vs;
      hs_o    <= s1_hs;
      de_o    <= s1_de;
      data_o  <= s1_data;
      if (vs_rise) begin
        lvl         <= '0;
        resid       <= '0;
        underflow_o <= 1'b0;
      end else begin
        if (starve) underflow_o <= 1'b1;
        if (de_i) begin
          lvl   <= next_lvl;
          resid <= next_resid;
        end else if (de_fall && C_LINE_ALIGN) begin
          // Residual bits are cleared with the level so a fresh word ORs onto zeros.
          lvl   <= '0;
          resid <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fb_rd_unpacker.sv
// Scoreboard bench for fb_rd_unpacker: a unit-stream model predicts pops and beats,
// a negedge monitor compares the delayed outputs against the expected queue.
module tb_fb_rd_unpacker;

  localparam int W     = 4;
  localparam int B     = 8;
  localparam int WB    = W * B;
  localparam int UW    = $clog2(W + 1);
  localparam bit ALIGN = 1'b1;

  typedef struct {
    int            stamp;
    logic          vs;
    logic          hs;
    logic          de;
    logic [WB-1:0] data;
  } exp_t;

  logic          clk_in = 1'b0;
  logic          rst = 1'b1;
  logic          vs_i = 1'b0, hs_i = 1'b0, de_i = 1'b0;
  logic [UW-1:0] units_i = UW'(3);
  logic [WB-1:0] fifo_data_i = '0;
  logic          fifo_empty_i = 1'b1;
  logic          fifo_rd_o, vs_o, hs_o, de_o, underflow_o, cfg_err_o;
  logic [WB-1:0] data_o;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  bit            mon_en = 1'b0;
  bit            force_empty = 1'b0;
  bit            auto_fill = 1'b0;

  logic [WB-1:0] fifo_q[$];
  logic [B-1:0]  mq[$];
  exp_t          exp_q[$];
  int            m_n = 3;
  bit            m_uf = 1'b0;
  bit            m_cfg = 1'b0;
  bit            m_vs_prev = 1'b0;
  bit            m_de_prev = 1'b0;

  fb_rd_unpacker #(
    .C_WORD_UNITS(W),
    .C_UNIT_BITS (B),
    .C_LINE_ALIGN(ALIGN)
  ) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .vs_i        (vs_i),
    .hs_i        (hs_i),
    .de_i        (de_i),
    .units_i     (units_i),
    .fifo_data_i (fifo_data_i),
    .fifo_empty_i(fifo_empty_i),
    .fifo_rd_o   (fifo_rd_o),
    .vs_o        (vs_o),
    .hs_o        (hs_o),
    .de_o        (de_o),
    .data_o      (data_o),
    .underflow_o (underflow_o),
    .cfg_err_o   (cfg_err_o)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit legal(input logic [UW-1:0] u);
    return (u >= 1) && (int'(u) <= W);
  endfunction

  // Monitor: each queued entry falls due at a given cycle; outside entries no beat may appear.
  always @(negedge clk_in) begin
    if (mon_en) begin
      if (exp_q.size() != 0 && exp_q[0].stamp == cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        check("vs_o", vs_o, e.vs);
        check("hs_o", hs_o, e.hs);
        check("de_o", de_o, e.de);
        check("data_o", data_o, e.data);
      end else begin
        check("stray_de_o", de_o, 1'b0);
      end
    end
  end

  // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic step(input logic v, input logic h, input logic d);
    logic [WB-1:0] beat;
    logic [WB-1:0] word;
    bit            exp_rd, starve, vs_rise, de_fall, rd_now;
    exp_t          e;
    if (auto_fill) while (fifo_q.size() < 2) fifo_q.push_back(WB'($urandom));
    vs_i = v; hs_i = h; de_i = d;
    fifo_empty_i = force_empty || (fifo_q.size() == 0);
    fifo_data_i  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    #1;
    check("underflow_o", underflow_o, m_uf);
    check("cfg_err_o", cfg_err_o, m_cfg);

    beat = '0; exp_rd = 1'b0; starve = 1'b0;
    if (d) begin
      if (mq.size() < m_n) begin
        if (!fifo_empty_i) begin
          exp_rd = 1'b1;
          word = fifo_q[0];
          for (int k = 0; k < W; k++) mq.push_back(word[k*B +: B]);
        end else begin
          starve = 1'b1;
        end
      end
      if (!starve) for (int k = 0; k < m_n; k++) beat[k*B +: B] = mq.pop_front();
    end
    check("fifo_rd_o", fifo_rd_o, exp_rd);

    vs_rise = v && !m_vs_prev;
    de_fall = !d && m_de_prev;
    if (vs_rise) begin
      mq.delete();
      m_uf = 1'b0;
    end else begin
      if (starve) m_uf = 1'b1;
      if (de_fall && ALIGN) mq.delete();
    end
    if (v) begin
      m_cfg = !legal(units_i);
      m_n   = legal(units_i) ? int'(units_i) : W;
    end
    m_vs_prev = v;
    m_de_prev = d;

    e.stamp = cyc + 2; e.vs = v; e.hs = h; e.de = d; e.data = beat;
    exp_q.push_back(e);
    rd_now = fifo_rd_o;
    @(posedge clk_in);
    if (rd_now && fifo_q.size() != 0) void'(fifo_q.pop_front());
    #1;
  endtask

  task automatic do_reset(input int cycles, input logic d);
    mon_en = 1'b0;
    exp_q.delete();
    rst = 1'b1; vs_i = 1'b0; hs_i = 1'b0; de_i = d;
    fifo_empty_i = (fifo_q.size() == 0);
    fifo_data_i  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    #1;
    check("rst_fifo_rd", fifo_rd_o, 1'b0);
    @(posedge clk_in); #1;
    check("rst_data_o", data_o, '0);
    check("rst_de_o", de_o, 1'b0);
    check("rst_vs_o", vs_o, 1'b0);
    check("rst_hs_o", hs_o, 1'b0);
    check("rst_underflow", underflow_o, 1'b0);
    check("rst_cfg_err", cfg_err_o, 1'b0);
    repeat (cycles - 1) @(posedge clk_in);
    #1;
    rst = 1'b0; de_i = 1'b0;
    mq.delete();
    m_uf = 1'b0; m_cfg = 1'b0;
    m_n = legal(units_i) ? int'(units_i) : W;
    m_vs_prev = 1'b0; m_de_prev = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic vsync(input logic [UW-1:0] u);
    units_i = u;
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic line(input int beats);
    step(1'b0, 1'b1, 1'b0);
    repeat (beats) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic load3();
    fifo_q.delete();
    fifo_q.push_back(32'h0302_0100);
    fifo_q.push_back(32'h0706_0504);
    fifo_q.push_back(32'h0B0A_0908);
  endtask

  initial begin
    do_reset(3, 1'b0);

    // 3-of-4 units over a 4-beat line: pops on the first three beats only.
    load3();
    vsync(UW'(3));
    line(4);

    // Short line then a new line: residual units are dropped at line end.
    load3();
    vsync(UW'(3));
    line(2);
    line(1);

    // Full-word beats: every beat pops and passes the word through.
    fifo_q.delete();
    for (int i = 0; i < 5; i++) fifo_q.push_back(WB'($urandom));
    vsync(UW'(4));
    line(5);

    // Starved beat: zero output, sticky flag until the next vertical sync.
    load3();
    vsync(UW'(3));
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    force_empty = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    force_empty = 1'b0;
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check("uf_sticky", underflow_o, 1'b1);
    vsync(UW'(3));
    check("uf_cleared", underflow_o, 1'b0);

    // Illegal unit count falls back to full words, then a single-unit config.
    fifo_q.delete();
    for (int i = 0; i < 3; i++) fifo_q.push_back(WB'($urandom));
    vsync(UW'(0));
    check("cfg_err_set", cfg_err_o, 1'b1);
    line(2);
    vsync(UW'(1));
    check("cfg_err_clr", cfg_err_o, 1'b0);
    line(3);

    // Reset mid-line with two residual units held.
    load3();
    vsync(UW'(3));
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    do_reset(2, 1'b1);
    line(2);

    // Randomized frames with mixed unit counts, de gaps and occasional starvation.
    fifo_q.delete();
    auto_fill = 1'b1;
    for (int f = 0; f < 25; f++) begin
      logic [UW-1:0] u;
      if ($urandom_range(0, 7) == 0)
        u = ($urandom_range(0, 1) == 0) ? UW'(0) : UW'($urandom_range(W + 1, (1 << UW) - 1));
      else
        u = UW'($urandom_range(1, W));
      vsync(u);
      for (int l = 0; l < 3; l++) begin
        step(1'b0, 1'b1, 1'b0);
        for (int b = 0, n = $urandom_range(1, 10); b < n; b++) begin
          force_empty = ($urandom_range(0, 19) == 0);
          step(1'b0, 1'b0, ($urandom_range(0, 5) != 0));
        end
        force_empty = 1'b0;
        step(1'b0, 1'b0, 1'b0);
      end
    end
    auto_fill = 1'b0;

    repeat (4) step(1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk_in);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
